// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, HALT opcode and FSM state type for the fetch stage
package fetch_pkg;
  localparam int INSTR_W  = 10;
  localparam int ADDR_W   = 8;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction
endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter register; branch load wins over sequential increment
module pc_counter
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with single-entry output buffer, branch flush and HALT stop
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]   RESET_PC    = 8'h00,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OP
) (
  input  logic               Clock,
  input  logic               Reset_n,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic               MemReq,
  input  logic [INSTR_W-1:0] MemData,
  input  logic               MemReady,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  output logic               Halted
);
  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;

  logic [ADDR_W-1:0]  pc;
  logic               in_fetch;
  logic               branch;
  logic               fetch_done;
  logic               consume;

  assign in_fetch   = (state_q == FETCH);
  assign branch     = in_fetch && BranchTaken;
  // A request is only issued when the buffer is empty or being drained this cycle.
  assign MemReq     = in_fetch && (!valid_q || !Stall) && !BranchTaken;
  assign fetch_done = MemReq && MemReady;
  assign consume    = valid_q && !Stall;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    if (branch) begin
      valid_d = 1'b0;
    end else if (fetch_done) begin
      instr_d    = MemData;
      instr_pc_d = pc;
      valid_d    = 1'b1;
      if (opcode_of(MemData) == HALT_OPCODE) begin
        halted_d = 1'b1;
        state_d  = HALTED;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= FETCH;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk       (Clock),
    .resetn    (Reset_n),
    .load      (branch),
    .load_addr (BranchTarget),
    .inc       (fetch_done),
    .pc        (pc)
  );

  assign MemAddr     = pc;
  assign Instruction = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = valid_q;
  assign Halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - table-driven and scoreboard bench for instr_fetch
module tb_instr_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] mem [256];

  // Instance A: RESET_PC = 0
  logic       rst_a = 1'b0, stall_a = 1'b0, br_a = 1'b0, rdy_a = 1'b0;
  logic [7:0] tgt_a = 8'h00;
  logic [7:0] addr_a, ipc_a;
  logic [9:0] data_a, instr_a;
  logic       req_a, valid_a, halted_a;
  assign data_a = mem[addr_a];

  instr_fetch #(.RESET_PC(8'h00), .HALT_OPCODE(4'hF)) dut_a (
    .Clock(clk), .Reset_n(rst_a), .MemAddr(addr_a), .MemReq(req_a),
    .MemData(data_a), .MemReady(rdy_a), .Stall(stall_a), .BranchTaken(br_a),
    .BranchTarget(tgt_a), .Instruction(instr_a), .InstrPC(ipc_a),
    .InstrValid(valid_a), .Halted(halted_a)
  );

  // Instance B: RESET_PC = FF for wrap and halt
  logic       rst_b = 1'b0, stall_b = 1'b0, br_b = 1'b0, rdy_b = 1'b0;
  logic [7:0] tgt_b = 8'h00;
  logic [7:0] addr_b, ipc_b;
  logic [9:0] data_b, instr_b;
  logic       req_b, valid_b, halted_b;
  assign data_b = mem[addr_b];

  instr_fetch #(.RESET_PC(8'hFF), .HALT_OPCODE(4'hF)) dut_b (
    .Clock(clk), .Reset_n(rst_b), .MemAddr(addr_b), .MemReq(req_b),
    .MemData(data_b), .MemReady(rdy_b), .Stall(stall_b), .BranchTaken(br_b),
    .BranchTarget(tgt_b), .Instruction(instr_b), .InstrPC(ipc_b),
    .InstrValid(valid_b), .Halted(halted_b)
  );

  typedef struct {
    logic       rst_n, stall, br, rdy;
    logic [7:0] tgt;
    logic       chk_pre, exp_req;
    logic [7:0] exp_addr;
    logic [9:0] exp_instr;
    logic [7:0] exp_ipc;
    logic       exp_v, exp_h;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst_n, input logic stall, input logic br, input logic rdy,
                     input logic [7:0] tgt, input logic chk_pre, input logic exp_req,
                     input logic [7:0] exp_addr, input logic [9:0] exp_instr,
                     input logic [7:0] exp_ipc, input logic exp_v, input logic exp_h);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.br = br; v.rdy = rdy; v.tgt = tgt;
    v.chk_pre = chk_pre; v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_instr = exp_instr; v.exp_ipc = exp_ipc; v.exp_v = exp_v; v.exp_h = exp_h;
    vecs.push_back(v);
  endtask

  initial begin
    logic        hs;
    logic [17:0] e;
    vec_t        v;

    for (int i = 0; i < 256; i++) mem[i] = 10'(i + 100);
    mem[0] = 10'd15;
    mem[1] = 10'd20;
    mem[2] = 10'd500;
    mem[8'hFF] = 10'h3C0;

    //  rst stl br rdy tgt    pre req addr    instr    ipc   v  h
    add(0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 10'd0,   8'h00, 0, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h00, 10'd15,  8'h00, 1, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h01, 10'd20,  8'h01, 1, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h02, 10'd500, 8'h02, 1, 0);
    add(0, 0, 0, 1, 8'h00, 1, 1, 8'h03, 10'd0,   8'h00, 0, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h00, 10'd15,  8'h00, 1, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h01, 10'd20,  8'h01, 1, 0);
    add(1, 1, 0, 1, 8'h00, 1, 0, 8'h02, 10'd20,  8'h01, 1, 0);
    add(1, 1, 0, 1, 8'h00, 1, 0, 8'h02, 10'd20,  8'h01, 1, 0);
    add(1, 1, 0, 1, 8'h00, 1, 0, 8'h02, 10'd20,  8'h01, 1, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h02, 10'd500, 8'h02, 1, 0);
    add(1, 1, 1, 1, 8'h40, 1, 0, 8'h03, 10'd500, 8'h02, 0, 0);
    add(1, 1, 0, 1, 8'h00, 1, 1, 8'h40, 10'd164, 8'h40, 1, 0);
    add(1, 1, 0, 1, 8'h00, 1, 0, 8'h41, 10'd164, 8'h40, 1, 0);
    add(0, 1, 0, 1, 8'h00, 1, 0, 8'h41, 10'd0,   8'h00, 0, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h00, 10'd15,  8'h00, 1, 0);
    add(1, 0, 0, 0, 8'h00, 1, 1, 8'h01, 10'd15,  8'h00, 0, 0);
    add(1, 0, 0, 1, 8'h00, 1, 1, 8'h01, 10'd20,  8'h01, 1, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      rst_a = v.rst_n; stall_a = v.stall; br_a = v.br; rdy_a = v.rdy; tgt_a = v.tgt;
      #1;
      if (v.chk_pre) begin
        chk($sformatf("row%0d MemReq", i), 32'(req_a), 32'(v.exp_req));
        chk($sformatf("row%0d MemAddr", i), 32'(addr_a), 32'(v.exp_addr));
      end
      if (v.rst_n && v.exp_req && v.rdy && !v.br) sb_q.push_back({v.exp_addr, mem[v.exp_addr]});
      hs = req_a && rdy_a && rst_a && !br_a;
      @(posedge clk); #1;
      chk($sformatf("row%0d Instruction", i), 32'(instr_a), 32'(v.exp_instr));
      chk($sformatf("row%0d InstrPC", i), 32'(ipc_a), 32'(v.exp_ipc));
      chk($sformatf("row%0d InstrValid", i), 32'(valid_a), 32'(v.exp_v));
      chk($sformatf("row%0d Halted", i), 32'(halted_a), 32'(v.exp_h));
      if (hs) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("row%0d sb unexpected fetch", i), 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("row%0d sb InstrPC", i), 32'(ipc_a), 32'(e[17:10]));
          chk($sformatf("row%0d sb Instruction", i), 32'(instr_a), 32'(e[9:0]));
        end
      end
    end
    chk("sb leftover entries", 32'(sb_q.size()), 32'(0));

    // Wrap and halt on instance B
    rst_b = 1'b0; stall_b = 1'b1; rdy_b = 1'b1;
    @(posedge clk); #1;
    chk("B reset Halted", 32'(halted_b), 32'(0));
    chk("B reset MemAddr", 32'(addr_b), 32'(8'hFF));
    rst_b = 1'b1; #1;
    chk("B first MemReq", 32'(req_b), 32'(1));
    @(posedge clk); #1;
    chk("B halt Instruction", 32'(instr_b), 32'(10'h3C0));
    chk("B halt InstrPC", 32'(ipc_b), 32'(8'hFF));
    chk("B halt InstrValid", 32'(valid_b), 32'(1));
    chk("B halt Halted", 32'(halted_b), 32'(1));
    chk("B wrap MemAddr", 32'(addr_b), 32'(8'h00));
    chk("B halt MemReq", 32'(req_b), 32'(0));
    br_b = 1'b1; tgt_b = 8'h40; #1;
    chk("B branch MemReq", 32'(req_b), 32'(0));
    @(posedge clk); #1;
    br_b = 1'b0;
    chk("B branch ignored MemAddr", 32'(addr_b), 32'(8'h00));
    chk("B branch ignored InstrValid", 32'(valid_b), 32'(1));
    chk("B branch ignored Halted", 32'(halted_b), 32'(1));
    stall_b = 1'b0; #1;
    chk("B consume MemReq", 32'(req_b), 32'(0));
    @(posedge clk); #1;
    chk("B consumed InstrValid", 32'(valid_b), 32'(0));
    chk("B consumed Halted", 32'(halted_b), 32'(1));
    chk("B consumed MemAddr", 32'(addr_b), 32'(8'h00));
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("B reset exit Halted", 32'(halted_b), 32'(0));
    chk("B reset exit MemAddr", 32'(addr_b), 32'(8'hFF));
    rst_b = 1'b1; #1;
    chk("B restart MemReq", 32'(req_b), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
